// File: rtl/prim_alert_rx_bank_pkg.sv
// prim_alert_rx_bank_pkg: shared handshake state encoding and link bit positions
package prim_alert_rx_bank_pkg;
    typedef enum logic [1:0] {Idle, HsAckWait, Pause} alert_state_e;
    localparam int RxW      = 4;
    localparam int TxW      = 2;
    localparam int RxPingP  = 3;
    localparam int RxPingN  = 2;
    localparam int RxAckP   = 1;
    localparam int RxAckN   = 0;
    localparam int TxAlertP = 1;
    localparam int TxAlertN = 0;
endpackage

// File: rtl/prim_alert_rx_bank_if.sv
// prim_alert_rx_bank_if: alert link bundle plus ping control/status for all channels
interface prim_alert_rx_bank_if #(
    parameter int NumAlerts    = 4,
    parameter int PingTimeoutW = 8
);
    import prim_alert_rx_bank_pkg::*;
    logic [NumAlerts-1:0]     ping_req;
    logic [PingTimeoutW-1:0]  ping_timeout_cyc;
    logic [NumAlerts-1:0]     ping_ok;
    logic [NumAlerts-1:0]     ping_timeout;
    logic [NumAlerts-1:0]     integ_fail;
    logic [NumAlerts-1:0]     alert;
    logic [RxW*NumAlerts-1:0] alert_rx;
    logic [TxW*NumAlerts-1:0] alert_tx;
    modport master (
        output ping_req, ping_timeout_cyc, alert_tx,
        input  ping_ok, ping_timeout, integ_fail, alert, alert_rx
    );
    modport slave (
        input  ping_req, ping_timeout_cyc, alert_tx,
        output ping_ok, ping_timeout, integ_fail, alert, alert_rx
    );
endinterface

// File: rtl/prim_alert_rx_bank_chan.sv
// prim_alert_rx_bank_chan: one alert link - decoder, ack handshake FSM, pause counter, ping timer
module prim_alert_rx_bank_chan
    import prim_alert_rx_bank_pkg::*;
#(
    parameter bit AsyncOn      = 1'b0,
    parameter int PauseCycles  = 2,
    parameter int PingTimeoutW = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    i_ping_req,
    input  logic [PingTimeoutW-1:0] i_ping_timeout,
    input  logic [TxW-1:0]          i_alert_tx,
    output logic                    o_ping_ok,
    output logic                    o_ping_timeout,
    output logic                    o_integ_fail,
    output logic                    o_alert,
    output logic [RxW-1:0]          o_alert_rx
);
    localparam int PauseW = PauseCycles > 1 ? $clog2(PauseCycles) : 1;
    localparam logic [PauseW-1:0] PauseLoad = PauseW'(PauseCycles - 1);

    logic [TxW-1:0] w_tx;

    if (AsyncOn) begin : g_sync
        logic [TxW-1:0] r_sync1, r_sync2;
        // two-flop synchroniser; resets to the idle pattern so no false integrity error
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_sync1 <= 2'b01;
                r_sync2 <= 2'b01;
            end else begin
                r_sync1 <= i_alert_tx;
                r_sync2 <= r_sync1;
            end
        end
        assign w_tx = r_sync2;
    end else begin : g_nosync
        assign w_tx = i_alert_tx;
    end

    alert_state_e            r_state;
    logic                    r_ack, r_tog, r_pend, r_req;
    logic [PauseW-1:0]       r_pause;
    logic [PingTimeoutW-1:0] r_timer;
    logic                    w_level, w_sigint, w_idle_hit, w_rise, w_tmo_en;

    assign w_sigint       = w_tx[TxAlertP] == w_tx[TxAlertN];
    assign w_level        = w_tx[TxAlertP];
    assign w_idle_hit     = r_state == Idle && w_level && !w_sigint;
    assign w_rise         = i_ping_req && !r_req;
    assign w_tmo_en       = r_pend && i_ping_timeout != '0;
    assign o_ping_ok      = w_idle_hit && r_pend;
    assign o_alert        = w_idle_hit && !r_pend;
    assign o_integ_fail   = w_sigint;
    assign o_ping_timeout = w_tmo_en && r_timer == PingTimeoutW'(1) && !o_ping_ok && i_ping_req;

    assign o_alert_rx[RxPingP] = r_tog;
    assign o_alert_rx[RxPingN] = ~r_tog;
    assign o_alert_rx[RxAckP]  = r_ack;
    assign o_alert_rx[RxAckN]  = ~r_ack;

    // handshake FSM: ack mirrors a clean alert level, then a fixed pause; a broken pair aborts to Idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= Idle;
            r_ack   <= 1'b0;
            r_pause <= '0;
        end else if (w_sigint) begin
            r_state <= Idle;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                Idle: begin
                    r_state <= w_level ? HsAckWait : Idle;
                    r_ack   <= w_level;
                end
                HsAckWait: begin
                    r_state <= w_level ? HsAckWait : Pause;
                    r_ack   <= w_level;
                    r_pause <= PauseLoad;
                end
                Pause: begin
                    r_state <= r_pause == '0 ? Idle : Pause;
                    r_ack   <= 1'b0;
                    r_pause <= r_pause - PauseW'(r_pause != '0);
                end
                default: begin
                    r_state <= Idle;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    // ping tracking: toggle per request edge, stay pending until answered, timed out or withdrawn
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req   <= 1'b0;
            r_tog   <= 1'b0;
            r_pend  <= 1'b0;
            r_timer <= '0;
        end else begin
            r_req   <= i_ping_req;
            r_tog   <= r_tog ^ w_rise;
            r_pend  <= w_rise || (r_pend && i_ping_req && !o_ping_ok && !o_ping_timeout);
            r_timer <= w_rise ? i_ping_timeout :
                       (w_tmo_en && r_timer != '0) ? r_timer - PingTimeoutW'(1) : r_timer;
        end
    end
endmodule

// File: rtl/prim_alert_rx_bank.sv
// prim_alert_rx_bank: NumAlerts independent alert receivers sharing one ping timeout setting
module prim_alert_rx_bank
    import prim_alert_rx_bank_pkg::*;
#(
    parameter int                   NumAlerts    = 4,
    parameter logic [NumAlerts-1:0] AsyncOn      = '0,
    parameter int                   PauseCycles  = 2,
    parameter int                   PingTimeoutW = 8
) (
    input logic                clk_i,
    input logic                rst_ni,
    prim_alert_rx_bank_if.slave bus
);
    for (genvar i = 0; i < NumAlerts; i++) begin : g_chan
        prim_alert_rx_bank_chan #(
            .AsyncOn      (AsyncOn[i]),
            .PauseCycles  (PauseCycles),
            .PingTimeoutW (PingTimeoutW)
        ) u_chan (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .i_ping_req     (bus.ping_req[i]),
            .i_ping_timeout (bus.ping_timeout_cyc),
            .i_alert_tx     (bus.alert_tx[TxW*i +: TxW]),
            .o_ping_ok      (bus.ping_ok[i]),
            .o_ping_timeout (bus.ping_timeout[i]),
            .o_integ_fail   (bus.integ_fail[i]),
            .o_alert        (bus.alert[i]),
            .o_alert_rx     (bus.alert_rx[RxW*i +: RxW])
        );
    end
endmodule

// File: tb/tb_prim_alert_rx_bank.sv
// tb_prim_alert_rx_bank: directed scenarios plus randomized traffic against a behavioural model
module tb_prim_alert_rx_bank;
    localparam int N = 4;
    localparam int P = 2;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    prim_alert_rx_bank_if #(.NumAlerts(N), .PingTimeoutW(W)) bus();

    prim_alert_rx_bank #(
        .NumAlerts(N), .AsyncOn('0), .PauseCycles(P), .PingTimeoutW(W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .bus(bus)
    );

    always #5 clk = ~clk;

    // behavioural model: busy flag for the ack phase, remaining pause cycles, ping bookkeeping
    logic [N-1:0]   m_busy, m_ack, m_tog, m_pend, m_req_q;
    int             m_pause [N];
    int             m_tmr [N];
    logic [N-1:0]   e_alert, e_ok, e_tmo, e_int, e_lvl, e_rise;
    logic [4*N-1:0] e_rx;

    always_comb begin
        e_alert = '0; e_ok = '0; e_tmo = '0; e_int = '0; e_lvl = '0; e_rise = '0; e_rx = '0;
        for (int i = 0; i < N; i++) begin
            e_lvl[i]   = bus.alert_tx[2*i+1];
            e_int[i]   = bus.alert_tx[2*i+1] == bus.alert_tx[2*i];
            e_rise[i]  = bus.ping_req[i] && !m_req_q[i];
            e_ok[i]    = !e_int[i] && !m_busy[i] && m_pause[i] == 0 && e_lvl[i] && m_pend[i];
            e_alert[i] = !e_int[i] && !m_busy[i] && m_pause[i] == 0 && e_lvl[i] && !m_pend[i];
            e_tmo[i]   = m_pend[i] && bus.ping_timeout_cyc != 0 && m_tmr[i] == 1 && !e_ok[i] && bus.ping_req[i];
            e_rx[4*i +: 4] = {m_tog[i], !m_tog[i], m_ack[i], !m_ack[i]};
        end
    end

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_busy <= '0; m_ack <= '0; m_tog <= '0; m_pend <= '0; m_req_q <= '0;
            for (int i = 0; i < N; i++) begin
                m_pause[i] <= 0;
                m_tmr[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                m_req_q[i] <= bus.ping_req[i];
                m_tog[i]   <= m_tog[i] ^ e_rise[i];
                m_pend[i]  <= e_rise[i] ? 1'b1 : (e_ok[i] || e_tmo[i] || !bus.ping_req[i]) ? 1'b0 : m_pend[i];
                m_tmr[i]   <= e_rise[i] ? int'(bus.ping_timeout_cyc) :
                              (m_pend[i] && bus.ping_timeout_cyc != 0 && m_tmr[i] > 0) ? m_tmr[i] - 1 : m_tmr[i];
                if (e_int[i]) begin
                    m_busy[i] <= 1'b0; m_ack[i] <= 1'b0; m_pause[i] <= 0;
                end else if (m_pause[i] > 0) begin
                    m_pause[i] <= m_pause[i] - 1; m_ack[i] <= 1'b0;
                end else begin
                    m_busy[i] <= e_lvl[i];
                    m_ack[i]  <= e_lvl[i];
                    if (m_busy[i] && !e_lvl[i]) m_pause[i] <= P;
                end
            end
        end
    end

    task automatic test_reset();
        #12;
        n_chk++; if (bus.alert_rx !== 16'h5555) begin n_fail++; $display("FAIL reset_rx got %h exp 5555", bus.alert_rx); end
        n_chk++; if ({bus.alert, bus.ping_ok, bus.ping_timeout, bus.integ_fail} !== 16'h0) begin
            n_fail++; $display("FAIL reset_pulses got %h exp 0", {bus.alert, bus.ping_ok, bus.ping_timeout, bus.integ_fail}); end
        @(posedge clk); #1; rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_chk++; if (bus.alert_rx !== 16'h5555 || {bus.alert, bus.ping_ok, bus.ping_timeout, bus.integ_fail} !== 16'h0) begin
                n_fail++; $display("FAIL idle_quiet c=%0d rx %h pulses %h", c, bus.alert_rx, {bus.alert, bus.ping_ok, bus.ping_timeout, bus.integ_fail}); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alert();
        int k;
        bus.alert_tx[1:0] = 2'b10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_chk++; if (bus.alert[0] !== (c == 0)) begin n_fail++; $display("FAIL alert_pulse c=%0d got %b exp %b", c, bus.alert[0], c == 0); end
            n_chk++; if (bus.alert_rx[1] !== (c != 0)) begin n_fail++; $display("FAIL ack_hold c=%0d got %b exp %b", c, bus.alert_rx[1], c != 0); end
            @(posedge clk); #1;
        end
        bus.alert_tx[1:0] = 2'b01;
        @(negedge clk);
        n_chk++; if (bus.alert_rx[1] !== 1'b1) begin n_fail++; $display("FAIL ack_release got %b exp 1", bus.alert_rx[1]); end
        @(posedge clk); #1;
        bus.alert_tx[1:0] = 2'b10;
        k = 1;
        @(negedge clk);
        n_chk++; if (bus.alert_rx[1] !== 1'b0) begin n_fail++; $display("FAIL ack_drop got %b exp 0", bus.alert_rx[1]); end
        while (!bus.alert[0] && k < 20) begin @(posedge clk); #1; k++; @(negedge clk); end
        n_chk++; if (k != P + 1) begin n_fail++; $display("FAIL pause_len got %0d exp %0d", k, P + 1); end
        @(posedge clk); #1;
        bus.alert_tx[1:0] = 2'b01;
        repeat (P + 3) @(posedge clk);
        #1;
    endtask

    task automatic test_ping();
        bus.ping_timeout_cyc = 8'd8;
        bus.ping_req[1] = 1'b1;
        for (int c = 0; c < 15; c++) begin
            bus.alert_tx[3:2] = (c >= 3 && c < 6) ? 2'b10 : 2'b01;
            @(negedge clk);
            n_chk++; if (bus.ping_ok[1] !== (c == 3)) begin n_fail++; $display("FAIL ping_ok c=%0d got %b exp %b", c, bus.ping_ok[1], c == 3); end
            n_chk++; if (bus.alert[1] !== 1'b0 || bus.ping_timeout[1] !== 1'b0) begin
                n_fail++; $display("FAIL ping_quiet c=%0d alert %b tmo %b exp 0 0", c, bus.alert[1], bus.ping_timeout[1]); end
            n_chk++; if (bus.alert_rx[7] !== (c != 0)) begin n_fail++; $display("FAIL ping_p c=%0d got %b exp %b", c, bus.alert_rx[7], c != 0); end
            @(posedge clk); #1;
        end
        bus.ping_req[1] = 1'b0;
    endtask

    task automatic test_timeout();
        bus.ping_timeout_cyc = 8'd5;
        bus.ping_req[2] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_chk++; if (bus.ping_timeout[2] !== (c == 5) || bus.ping_ok[2] !== 1'b0) begin
                n_fail++; $display("FAIL tmo5 c=%0d tmo %b ok %b exp %b 0", c, bus.ping_timeout[2], bus.ping_ok[2], c == 5); end
            @(posedge clk); #1;
        end
        bus.ping_req[2] = 1'b0;
        bus.ping_timeout_cyc = 8'd0;
        @(posedge clk); #1;
        bus.ping_req[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_chk++; if (bus.ping_timeout[2] !== 1'b0) begin n_fail++; $display("FAIL tmo0 c=%0d got %b exp 0", c, bus.ping_timeout[2]); end
            @(posedge clk); #1;
        end
        bus.ping_req[2] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_integ();
        for (int c = 0; c < 8; c++) begin
            bus.alert_tx[7:6] = (c < 2 || c == 5) ? 2'b10 : (c < 4) ? 2'b11 : 2'b01;
            @(negedge clk);
            n_chk++; if (bus.integ_fail[3] !== (c == 2 || c == 3)) begin
                n_fail++; $display("FAIL integ c=%0d got %b exp %b", c, bus.integ_fail[3], c == 2 || c == 3); end
            n_chk++; if (bus.alert_rx[13] !== (c == 1 || c == 2 || c == 6)) begin
                n_fail++; $display("FAIL integ_ack c=%0d got %b exp %b", c, bus.alert_rx[13], c == 1 || c == 2 || c == 6); end
            n_chk++; if (bus.alert[3] !== (c == 0 || c == 5)) begin
                n_fail++; $display("FAIL integ_alert c=%0d got %b exp %b", c, bus.alert[3], c == 0 || c == 5); end
            n_chk++; if ({bus.alert[2:0], bus.ping_ok[2:0], bus.ping_timeout[2:0], bus.integ_fail[2:0]} !== 12'h0 || bus.alert_rx[11:0] !== 12'h595) begin
                n_fail++; $display("FAIL integ_others c=%0d rx %h exp 595", c, bus.alert_rx[11:0]); end
            @(posedge clk); #1;
        end
        repeat (P + 2) @(posedge clk);
        #1;
    endtask

    task automatic test_race_and_abort();
        bus.ping_timeout_cyc = 8'd4;
        for (int c = 0; c < 11; c++) begin
            bus.ping_req[1] = c < 7;
            bus.alert_tx[3:2] = (c == 4 || c == 5) ? 2'b10 : 2'b01;
            @(negedge clk);
            n_chk++; if (bus.ping_ok[1] !== (c == 4) || bus.ping_timeout[1] !== 1'b0 || bus.alert[1] !== 1'b0) begin
                n_fail++; $display("FAIL race c=%0d ok %b tmo %b alert %b exp %b 0 0", c, bus.ping_ok[1], bus.ping_timeout[1], bus.alert[1], c == 4); end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 12; c++) begin
            bus.ping_req[1] = c < 2;
            @(negedge clk);
            n_chk++; if ({bus.ping_ok[1], bus.ping_timeout[1], bus.alert[1]} !== 3'b000) begin
                n_fail++; $display("FAIL abort c=%0d got %b exp 000", c, {bus.ping_ok[1], bus.ping_timeout[1], bus.alert[1]}); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        bus.alert_tx[1:0] = 2'b10;
        bus.ping_timeout_cyc = 8'd3;
        bus.ping_req[2] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_chk++; if (bus.alert_rx[1] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ack got %b exp 1", bus.alert_rx[1]); end
        #2 rst_ni = 1'b0; bus.alert_tx[1:0] = 2'b01;
        #1;
        n_chk++; if (bus.alert_rx !== 16'h5555 || {bus.alert, bus.ping_ok, bus.ping_timeout, bus.integ_fail} !== 16'h0) begin
            n_fail++; $display("FAIL mid_reset rx %h exp 5555", bus.alert_rx); end
        bus.ping_req[2] = 1'b0;
        @(posedge clk); #1; rst_ni = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_chk++; if ({bus.alert, bus.ping_ok, bus.ping_timeout, bus.integ_fail} !== 16'h0) begin
                n_fail++; $display("FAIL post_reset c=%0d pulses %h exp 0", c, {bus.alert, bus.ping_ok, bus.ping_timeout, bus.integ_fail}); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < 20) begin
                    r = $urandom_range(0, 99);
                    bus.alert_tx[2*i +: 2] = r < 65 ? 2'b01 : r < 94 ? 2'b10 : r < 97 ? 2'b11 : 2'b00;
                end
                if ($urandom_range(0, 99) < 8) bus.ping_req[i] = ~bus.ping_req[i];
            end
            if ($urandom_range(0, 99) < 3) bus.ping_timeout_cyc = W'($urandom_range(0, 6));
            @(negedge clk);
            n_chk++; if (bus.alert !== e_alert) begin n_fail++; $display("FAIL rnd_alert c=%0d got %b exp %b", c, bus.alert, e_alert); end
            n_chk++; if (bus.ping_ok !== e_ok) begin n_fail++; $display("FAIL rnd_ping_ok c=%0d got %b exp %b", c, bus.ping_ok, e_ok); end
            n_chk++; if (bus.ping_timeout !== e_tmo) begin n_fail++; $display("FAIL rnd_timeout c=%0d got %b exp %b", c, bus.ping_timeout, e_tmo); end
            n_chk++; if (bus.integ_fail !== e_int) begin n_fail++; $display("FAIL rnd_integ c=%0d got %b exp %b", c, bus.integ_fail, e_int); end
            n_chk++; if (bus.alert_rx !== e_rx) begin n_fail++; $display("FAIL rnd_rx c=%0d got %h exp %h", c, bus.alert_rx, e_rx); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.alert_tx = {N{2'b01}};
        bus.ping_req = '0;
        bus.ping_timeout_cyc = '0;
        test_reset();
        test_alert();
        test_ping();
        test_timeout();
        test_integ();
        test_race_and_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d checks", n_chk);
        $fatal(1, "watchdog");
    end
endmodule
